// File: rtl/rf_port_sequencer.sv
// Operand-fetch sequencer: time-shares one combinational RF read port between rs1 and rs2,
// drives the RF write port from write-back, and keeps held operands coherent until consumed.
module rf_port_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  input  logic                  req_use_rs2,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_op1,
  output logic [DATA_WIDTH-1:0] resp_op2,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  output logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic [ADDR_WIDTH-1:0] rf_rs1_addr,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data,
  output logic                  busy
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD1  = 2'd1,
    S_RD2  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_op1;
  logic [DW-1:0]   r_op2;
  logic [AW-1:0]   r_rs1_q;
  logic [AW-1:0]   r_rs2_q;
  logic            r_use2_q;
  logic [DW-1:0]   w_op1_nxt;
  logic [DW-1:0]   w_op2_nxt;
  logic [AW-1:0]   w_rs1_q_nxt;
  logic [AW-1:0]   w_rs2_q_nxt;
  logic            w_use2_q_nxt;
  logic [AW-1:0]   w_rs1_addr;
  logic            w_wb_hit1;
  logic            w_wb_hit2;
  logic [DW-1:0]   w_fwd1;
  logic [DW-1:0]   w_fwd2;

  // Idle write cycles are steered to x0, which the register file never stores.
  assign rf_rd_addr = wb_valid ? wb_addr : '0;
  assign rf_rd_data = wb_valid ? wb_data : '0;

  // A write-back to a held source register (never x0) lands on the same edge as the read.
  assign w_wb_hit1 = wb_valid && (wb_addr == r_rs1_q) && (r_rs1_q != '0);
  assign w_wb_hit2 = wb_valid && (wb_addr == r_rs2_q) && (r_rs2_q != '0);
  assign w_fwd1    = w_wb_hit1 ? wb_data : rf_rs1_data;
  assign w_fwd2    = w_wb_hit2 ? wb_data : rf_rs1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op1    <= '0;
      r_op2    <= '0;
      r_rs1_q  <= '0;
      r_rs2_q  <= '0;
      r_use2_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op1    <= w_op1_nxt;
      r_op2    <= w_op2_nxt;
      r_rs1_q  <= w_rs1_q_nxt;
      r_rs2_q  <= w_rs2_q_nxt;
      r_use2_q <= w_use2_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_op1_nxt    = r_op1;
    w_op2_nxt    = r_op2;
    w_rs1_q_nxt  = r_rs1_q;
    w_rs2_q_nxt  = r_rs2_q;
    w_use2_q_nxt = r_use2_q;
    w_rs1_addr   = '0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_rs1_q_nxt  = req_rs1;
          w_rs2_q_nxt  = req_rs2;
          w_use2_q_nxt = req_use_rs2;
          w_state_nxt  = S_RD1;
        end
      end
      S_RD1: begin
        w_rs1_addr = r_rs1_q;
        w_op1_nxt  = w_fwd1;
        if (r_use2_q) begin
          w_state_nxt = S_RD2;
        end else begin
          w_op2_nxt   = '0;
          w_state_nxt = S_RESP;
        end
      end
      S_RD2: begin
        w_rs1_addr  = r_rs2_q;
        w_op2_nxt   = w_fwd2;
        if (w_wb_hit1) w_op1_nxt = wb_data;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        // Keep held operands current, including on the handshake edge.
        if (w_wb_hit1) w_op1_nxt = wb_data;
        if (r_use2_q && w_wb_hit2) w_op2_nxt = wb_data;
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rf_rs1_addr = w_rs1_addr;
  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_op1    = r_op1;
  assign resp_op2    = r_op2;

endmodule

// File: tb/tb_rf_port_sequencer.sv
// Bench for rf_port_sequencer: a behavioural register file, an architectural-state reference
// model, directed scenarios and a randomized phase.
module tb_rf_port_sequencer;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_rs1 = '0;
  logic [AW-1:0] req_rs2 = '0;
  logic          req_use_rs2 = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_op1;
  logic [DW-1:0] resp_op2;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic [AW-1:0] rf_rs1_addr;
  logic [DW-1:0] rf_rs1_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Register file environment: writes every edge, x0 never stored, combinational read.
  logic [DW-1:0] rf_mem [NREG] = '{default: '0};
  // Reference architectural register values.
  logic [DW-1:0] arch [NREG] = '{default: '0};

  // Reference transaction model: cycles since acceptance and required latency.
  bit            m_busy = 1'b0;
  int            m_age  = 0;
  int            m_lat  = 0;
  logic [AW-1:0] m_rs1  = '0;
  logic [AW-1:0] m_rs2  = '0;
  bit            m_use2 = 1'b0;

  rf_port_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_use_rs2 (req_use_rs2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_op1    (resp_op1),
    .resp_op2    (resp_op2),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs1_data (rf_rs1_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_rd_addr != '0) rf_mem[rf_rd_addr] <= rf_rd_data;
  end
  assign rf_rs1_data = rf_mem[rf_rs1_addr];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] arch_val(input logic [AW-1:0] a);
    return (a == '0) ? '0 : arch[a];
  endfunction

  task automatic model_edge();
    if (wb_valid && wb_addr != '0) arch[wb_addr] = wb_data;
    if (!rst_n) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_rs1  = req_rs1;
        m_rs2  = req_rs2;
        m_use2 = req_use_rs2;
        m_lat  = req_use_rs2 ? 3 : 2;
      end
    end else if (m_age >= m_lat) begin
      if (resp_ready) m_busy = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_state();
    bit exp_valid;
    exp_valid = m_busy && (m_age >= m_lat);
    check_eq("req_ready", 32'(req_ready), 32'(!m_busy));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("resp_valid", 32'(resp_valid), 32'(exp_valid));
    if (exp_valid) begin
      check_eq("resp_op1", resp_op1, arch_val(m_rs1));
      check_eq("resp_op2", resp_op2, m_use2 ? arch_val(m_rs2) : '0);
    end
  endtask

  // One clock: inputs were set at the preceding negedge.
  task automatic step();
    #1;
    check_eq("rf_rd_addr", 32'(rf_rd_addr), wb_valid ? 32'(wb_addr) : 32'd0);
    check_eq("rf_rd_data", rf_rd_data, wb_valid ? wb_data : '0);
    if (!m_busy && !req_valid) check_eq("rs_addr_idle", 32'(rf_rs1_addr), 32'd0);
    else if (m_busy && m_age == 1) check_eq("rs_addr_rd1", 32'(rf_rs1_addr), 32'(m_rs1));
    else if (m_busy && m_age == 2 && m_use2) check_eq("rs_addr_rd2", 32'(rf_rs1_addr), 32'(m_rs2));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_state();
  endtask

  task automatic set_wb(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  task automatic issue(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic u2);
    req_valid   = 1'b1;
    req_rs1     = r1;
    req_rs2     = r2;
    req_use_rs2 = u2;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_op1", resp_op1, '0);
    check_eq("rst_op2", resp_op2, '0);
    @(negedge clk);
    rst_n = 1'b1;

    set_wb(1'b1, 5'd5, 32'h11); step();
    set_wb(1'b1, 5'd6, 32'h22); step();
    set_wb(1'b0, '0, '0);

    // Plain fetch, response in cycle 3.
    resp_ready = 1'b1;
    issue(5'd5, 5'd6, 1'b1);
    check_eq("t1_busy_c1", 32'(busy), 32'd1);
    step(); step();
    check_eq("t1_valid_c3", 32'(resp_valid), 32'd1);
    check_eq("t1_op1", resp_op1, 32'h11);
    check_eq("t1_op2", resp_op2, 32'h22);
    step();

    // Same-edge forwarding in RD1, and x0 never forwarded.
    issue(5'd5, 5'd6, 1'b1);
    set_wb(1'b1, 5'd5, 32'hAA); step();
    set_wb(1'b0, '0, '0); step();
    check_eq("t2_op1_fwd", resp_op1, 32'hAA);
    step();
    issue(5'd0, 5'd6, 1'b1);
    set_wb(1'b1, 5'd0, 32'hFF); step();
    set_wb(1'b0, '0, '0); step();
    check_eq("t2_op1_x0", resp_op1, 32'h0);
    step();

    // Stall coherence in RESP.
    resp_ready = 1'b0;
    issue(5'd5, 5'd6, 1'b1);
    step(); step();
    set_wb(1'b1, 5'd6, 32'h33); step();
    check_eq("t3_op2_upd", resp_op2, 32'h33);
    check_eq("t3_op1_hold", resp_op1, 32'hAA);
    set_wb(1'b0, '0, '0);
    resp_ready = 1'b1;
    step();
    check_eq("t3_idle", 32'(busy), 32'd0);

    // No rs2: response in cycle 2, op2 zero; request while busy is not taken.
    issue(5'd5, 5'd6, 1'b0);
    req_valid = 1'b1; req_rs1 = 5'd6;
    resp_ready = 1'b0;
    step();
    check_eq("t4_valid_c2", 32'(resp_valid), 32'd1);
    check_eq("t4_op2_zero", resp_op2, 32'h0);
    check_eq("t4_not_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    step();
    check_eq("t4_not_taken", 32'(busy), 32'd0);

    // Idle write port.
    repeat (10) step();
    check_eq("t5_x5", rf_mem[5], 32'hAA);
    check_eq("t5_x6", rf_mem[6], 32'h33);

    // Asynchronous reset in RD2.
    issue(5'd5, 5'd6, 1'b1);
    step();
    rst_n = 1'b0;
    m_busy = 1'b0;
    #1;
    check_eq("t6_valid_async", 32'(resp_valid), 32'd0);
    check_eq("t6_busy_async", 32'(busy), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check_eq("t6_ready", 32'(req_ready), 32'd1);
    repeat (4) step();

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n  = 1'b0;
        m_busy = 1'b0;
      end
      req_valid   = ($urandom_range(0, 1) == 1);
      req_rs1     = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      req_rs2     = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      req_use_rs2 = ($urandom_range(0, 3) != 0);
      resp_ready  = ($urandom_range(0, 2) != 0);
      set_wb($urandom_range(0, 1) == 1,
             ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
             DW'($urandom));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
